// File: rtl/rom_mult_sequencer.sv
// Sequencer in front of a lookup-table multiplier ROM: accept operands, pulse the ROM read, hold the product.
// Optional: define ROM_MULT_ZERO_BYPASS_EN to answer zero operands without reading the ROM.
module rom_mult_sequencer #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N/2-1:0] op_a,
  input  logic [N/2-1:0] op_b,
  output logic [N-1:0]   rom_address,
  output logic           rom_ce,
  output logic           rom_read_en,
  input  logic [N-1:0]   rom_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           in_ready_q, in_ready_d;
  logic [N-1:0]   addr_q, addr_d;
  logic           rom_en_q, rom_en_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   product_q, product_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      addr_q      <= '0;
      rom_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      addr_q      <= addr_d;
      rom_en_q    <= rom_en_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    addr_d      = addr_q;
    rom_en_d    = rom_en_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          addr_d     = {op_a, op_b};
          in_ready_d = 1'b0;
`ifdef ROM_MULT_ZERO_BYPASS_EN
          // A zero operand makes the product zero; skip the ROM entirely.
          if ((op_a == '0) || (op_b == '0)) begin
            product_d   = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            rom_en_d = 1'b1;
            state_d  = READ;
          end
`else
          rom_en_d = 1'b1;
          state_d  = READ;
`endif
        end
      end
      READ: begin
        product_d   = rom_data;
        rom_en_d    = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        // Unreachable encoding: fall back to an idle, empty sequencer.
        rom_en_d    = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  assign in_ready    = in_ready_q;
  assign rom_address = addr_q;
  assign rom_ce      = rom_en_q;
  assign rom_read_en = rom_en_q;
  assign out_valid   = out_valid_q;
  assign product     = product_q;

endmodule

// File: tb/tb_rom_mult_sequencer.sv
// Testbench for rom_mult_sequencer: table-driven directed vectors, corner sequences, randomized scoreboard.
module tb_rom_mult_sequencer;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N/2-1:0] op_a = '0;
  logic [N/2-1:0] op_b = '0;
  logic [N-1:0]   rom_address;
  logic           rom_ce;
  logic           rom_read_en;
  logic [N-1:0]   rom_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N-1:0]   product;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  rom_mult_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .rom_address(rom_address), .rom_ce(rom_ce),
    .rom_read_en(rom_read_en), .rom_data(rom_data), .out_valid(out_valid),
    .out_ready(out_ready), .product(product)
  );

  function automatic logic [N-1:0] mul(input logic [N/2-1:0] a, input logic [N/2-1:0] b);
    logic [N-1:0] ea, eb;
    ea = N'(a);
    eb = N'(b);
    return ea * eb;
  endfunction

  // Multiplier ROM: combinational lookup, drives 0 when not enabled.
  assign rom_data = (rom_ce && rom_read_en) ? mul(rom_address[N-1:N/2], rom_address[N/2-1:0]) : '0;

  function automatic bit bypassed(input logic [N/2-1:0] a, input logic [N/2-1:0] b);
`ifdef ROM_MULT_ZERO_BYPASS_EN
    return (a == 0) || (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation with immediate consumption; checks address, latency, ROM pulses, product.
  task automatic do_op(input string tag, input logic [N/2-1:0] a, input logic [N/2-1:0] b,
                       input logic [N-1:0] exp_addr, input logic [N-1:0] exp_prod);
    int lat, ce_cnt;
    @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; op_a = ~a; op_b = ~b;
    chk({tag, "_addr"}, 32'(rom_address), 32'(exp_addr));
    chk({tag, "_in_ready_low"}, 32'(in_ready), 0);
    lat = 1;
    ce_cnt = (rom_ce && rom_read_en) ? 1 : 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
      if (rom_ce) ce_cnt++;
    end
    chk({tag, "_latency"}, 32'(lat), bypassed(a, b) ? 1 : 2);
    chk({tag, "_product"}, 32'(product), 32'(exp_prod));
    chk({tag, "_rom_pulses"}, 32'(ce_cnt), bypassed(a, b) ? 0 : 1);
    tick();
    chk({tag, "_ready_back"}, 32'({in_ready, out_valid, rom_ce}), 32'b100);
  endtask

  typedef struct {
    logic [N/2-1:0] a;
    logic [N/2-1:0] b;
    logic [N-1:0]   addr;
    logic [N-1:0]   prod;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [N-1:0] q[$];
    int accepts, ce_seen, seen, last_t, gaps_ok, cyc;
    logic [N-1:0] got[$];

    vecs[0] = '{4'd3,  4'd5,  8'h35, 8'h0F};
    vecs[1] = '{4'd15, 4'd15, 8'hFF, 8'hE1};
    vecs[2] = '{4'd0,  4'd11, 8'h0B, 8'h00};
    vecs[3] = '{4'd12, 4'd10, 8'hCA, 8'h78};
    vecs[4] = '{4'd1,  4'd1,  8'h11, 8'h01};
    vecs[5] = '{4'd9,  4'd0,  8'h90, 8'h00};

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_outs", 32'({rom_address, rom_ce, rom_read_en, out_valid, product}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].addr, vecs[i].prod);

    // Backpressure: product holds, no second accept until handoff
    @(negedge clk);
    in_valid = 1'b1; op_a = 4'd7; op_b = 4'd9; out_ready = 1'b0;
    tick();
    @(negedge clk);
    op_a = 4'd2; op_b = 4'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_product", 32'(product), 32'h3F);
      chk("bp_hold_state", 32'({in_ready, out_valid, rom_address}), 32'({2'b01, 8'h79}));
      tick();
    end
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    chk("bp_handoff", 32'({in_ready, out_valid}), 32'b10);
    tick();
    chk("bp_second_accept", 32'({in_ready, rom_ce, rom_address}), 32'({2'b01, 8'h22}));
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("bp_second_product", 32'({out_valid, product}), 32'({1'b1, 8'h04}));
    tick();

    // Back-to-back: four pairs, products 3 cycles apart, four ROM pulses
    seen = 0; ce_seen = 0; last_t = -1; gaps_ok = 1; accepts = 0; cyc = 0;
    got.delete();
    while (seen < 4 && cyc < 40) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got.push_back(product);
        if (last_t >= 0 && cyc - last_t != 3) gaps_ok = 0;
        last_t = cyc;
        seen++;
      end
      if (rom_ce) ce_seen++;
      if (in_ready && in_valid) accepts++;
      in_valid = (accepts < 4);
      op_a = vecs[accepts % 6].a + 4'd1;
      op_b = vecs[accepts % 6].b + 4'd2;
      out_ready = 1'b1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(seen), 4);
    chk("b2b_spacing", 32'(gaps_ok), 1);
    chk("b2b_rom_pulses", 32'(ce_seen), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b_prod%0d", i), 32'((got.size() > i) ? got[i] : 8'hxx),
          32'(mul(vecs[i].a + 4'd1, vecs[i].b + 4'd2)));
    tick();

    // Reset while in READ
    @(negedge clk);
    in_valid = 1'b1; op_a = 4'd6; op_b = 4'd6;
    tick();
    in_valid = 1'b0;
    chk("rmo_in_read", 32'(rom_ce), 1);
    #2 rst = 1'b1;
    #1;
    chk("rmo_cleared", 32'({rom_ce, rom_read_en, out_valid, product}), 0);
    chk("rmo_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rmo_no_output", 32'(seen), 0);

    // Randomized traffic against a queue scoreboard
    q.delete();
    accepts = 0; ce_seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op_a = (c % 17 == 0) ? 4'd0 : 4'($urandom);
      op_b = 4'($urandom);
      if (rom_ce) ce_seen++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious_out", 32'(out_valid), 0);
        else chk("rnd_product", 32'(product), 32'(q.pop_front()));
      end
      if (in_valid && in_ready) begin
        chk("rnd_one_in_flight", 32'(q.size()), 0);
        q.push_back(mul(op_a, op_b));
        if (!bypassed(op_a, op_b)) accepts++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (rom_ce) ce_seen++;
      if (out_valid && out_ready && q.size() > 0) chk("rnd_drain_product", 32'(product), 32'(q.pop_front()));
      @(negedge clk);
    end
    chk("rnd_drained", 32'(q.size()), 0);
    chk("rnd_rom_pulses", 32'(ce_seen), 32'(accepts));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
